// File: rtl/io_bus_bridge_pkg.sv
// Shared definitions for the CPU-to-IO bus bridge.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
// Contents: bus FSM state encoding, default error read data, timer width helper.
package io_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Bits needed to count 0..timeout.
  function automatic int timer_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/io_bus_bridge_if.sv
// Bundle of CPU request/response, IO device strobes and interrupt relay signals.
// Latency: n/a (wires only).
// Backpressure: n/a; master = bridge side, slave = CPU/device/CU side.
// Ports: cpu_* request/response, io_* device bus and interrupt, cu_* CU interrupt.
interface io_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_out;
  logic [DATA_W-1:0] io_in;
  logic              io_cs;
  logic              io_rd;
  logic              io_wr;
  logic              io_rdy;
  logic              io_intr;
  logic              io_intr_ack;
  logic              cu_intr;
  logic              cu_intr_ack;

  modport master (
    input  cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata, io_in, io_rdy, io_intr, cu_intr_ack,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err, io_addr, io_out, io_cs, io_rd, io_wr,
           io_intr_ack, cu_intr
  );

  modport slave (
    output cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata, io_in, io_rdy, io_intr, cu_intr_ack,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err, io_addr, io_out, io_cs, io_rd, io_wr,
           io_intr_ack, cu_intr
  );
endinterface

// File: rtl/io_bus_bridge_intr_relay.sv
// Relays a device interrupt level to the CU as a held request and returns the CU ack.
// Latency: cu_intr rises 1 cycle after io_intr rises; io_intr_ack 1 cycle after cu_intr_ack.
// Backpressure: none; acks while nothing is pending are ignored.
// Ports: i clk/reset, io_intr, cu_intr_ack; o cu_intr, io_intr_ack.
module io_intr_relay (
  input  logic clk,
  input  logic reset,
  input  logic io_intr,
  input  logic cu_intr_ack,
  output logic cu_intr,
  output logic io_intr_ack
);

  logic r_intr_q;
  logic r_pending;
  logic r_ack;
  logic w_rise;

  // Edge-triggered: a level held high after an ack does not re-raise pending.
  assign w_rise = io_intr & ~r_intr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_intr_q  <= 1'b0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_intr_q <= io_intr;
      r_ack    <= cu_intr_ack & r_pending;
      // A fresh edge in the ack cycle keeps pending set (set has priority).
      if (w_rise)
        r_pending <= 1'b1;
      else if (cu_intr_ack)
        r_pending <= 1'b0;
    end
  end

  assign cu_intr     = r_pending;
  assign io_intr_ack = r_ack;

endmodule

// File: rtl/io_bus_bridge.sv
// CPU load/store to IO device strobe bridge with read timeout and interrupt relay.
// Latency: write done 2 cycles after accept; read done (waits+2), timeout at TIMEOUT+1.
// Backpressure: requests are taken only in IDLE; anything arriving while busy is dropped.
// Ports: i sys_clk, reset; bus (master modport) carrying cpu_*, io_* and cu_* signals.
module io_bus_bridge
  import io_bridge_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic            sys_clk,
  input  logic            reset,
  io_bus_bridge_if.master bus
);

  localparam int TW = timer_w(TIMEOUT);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [TW-1:0]     r_timer;

  logic w_misaligned;
  logic w_timeout;
  logic w_sel;

  assign w_misaligned = bus.cpu_addr[1:0] != 2'b00;
  // r_timer counts completed rdy-less RD cycles; the current one is the last allowed.
  assign w_timeout    = r_timer == TW'(TIMEOUT - 1);
  assign w_sel        = (r_state == ST_RD) || (r_state == ST_WR);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_rd_req || bus.cpu_wr_req) begin
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_err   <= w_misaligned;
            // Misaligned accesses complete with error without touching the device.
            if (w_misaligned)
              r_state <= ST_DONE;
            else if (bus.cpu_rd_req)
              r_state <= ST_RD;
            else
              r_state <= ST_WR;
          end
        end
        ST_RD: begin
          // io_in is only captured with rdy, so a floating bus is never latched.
          if (bus.io_rdy) begin
            r_rdata <= bus.io_in;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_rdata <= DATA_W'(ERR_DATA);
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_WR: r_state <= ST_DONE;
        default: begin
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.io_cs     = w_sel;
  assign bus.io_rd     = r_state == ST_RD;
  assign bus.io_wr     = r_state == ST_WR;
  assign bus.io_addr   = w_sel ? r_addr : '0;
  assign bus.io_out    = w_sel ? r_wdata : '0;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_busy  = r_state != ST_IDLE;
  assign bus.cpu_done  = r_state == ST_DONE;
  assign bus.cpu_err   = (r_state == ST_DONE) && r_err;

  io_intr_relay u_intr_relay (
    .clk         (sys_clk),
    .reset       (reset),
    .io_intr     (bus.io_intr),
    .cu_intr_ack (bus.cu_intr_ack),
    .cu_intr     (bus.cu_intr),
    .io_intr_ack (bus.io_intr_ack)
  );

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: scenario tasks with a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_bus_bridge;

  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] m_rdata = '0;

  io_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  io_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drives one request and plays the device: rdy is given on RD cycle waits+1.
  // Returns done latency (cycles after the accept edge, 0 if done never rose), err,
  // strobe counts and whether bus values were consistent throughout.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdat,
                         output int lat, output bit err, output int cs_n, output int wr_n,
                         output bit ok);
    int rd_seen;
    lat = 0; err = 1'b0; cs_n = 0; wr_n = 0; ok = 1'b1; rd_seen = 0;
    bus.cpu_rd_req = rd; bus.cpu_wr_req = wr;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    tick();
    bus.cpu_rd_req = 1'b0; bus.cpu_wr_req = 1'b0;
    bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (bus.cpu_busy !== 1'b1) ok = 1'b0;
      bus.io_rdy = 1'b0;
      bus.io_in  = $urandom;
      if (bus.io_cs === 1'b1) begin
        cs_n++;
        if (bus.io_wr === 1'b1) wr_n++;
        if (bus.io_addr !== addr || bus.io_out !== wdata) ok = 1'b0;
        if (bus.io_rd === 1'b1) begin
          rd_seen++;
          if (rd_seen == waits + 1) begin
            bus.io_rdy = 1'b1;
            bus.io_in  = rdat;
          end
        end
      end else if (bus.io_addr !== 32'h0 || bus.io_out !== 32'h0) begin
        ok = 1'b0;
      end
      if (bus.cpu_done === 1'b1) begin
        lat = c;
        err = bus.cpu_err;
        break;
      end
      tick();
    end
    bus.io_rdy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.io_cs, bus.io_rd, bus.io_wr,
         bus.cu_intr, bus.io_intr_ack} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000", {bus.cpu_busy, bus.cpu_done,
               bus.cpu_err, bus.io_cs, bus.io_rd, bus.io_wr, bus.cu_intr, bus.io_intr_ack});
    end
    n_checks++;
    if (bus.cpu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata);
    end
    n_checks++;
    if (bus.io_addr !== 32'h0 || bus.io_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_iobus: addr %h out %h want 0", bus.io_addr, bus.io_out);
    end
    reset = 1'b0;
    m_rdata = '0;
    tick();
  endtask

  task automatic test_write();
    int lat, cs_n, wr_n; bit err, ok;
    logic [31:0] a, d;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 32'h10 : ($urandom & 32'hFFFF_FFFC);
      d = (i == 0) ? 32'hCAFEBABE : $urandom;
      run_txn(1'b0, 1'b1, a, d, 0, 32'h0, lat, err, cs_n, wr_n, ok);
      n_checks++;
      if (lat != 2 || err !== 1'b0) begin
        n_fail++; $display("FAIL write_done[%0d]: lat %0d err %b want 2 0", i, lat, err);
      end
      n_checks++;
      if (cs_n != 1 || wr_n != 1 || !ok) begin
        n_fail++;
        $display("FAIL write_strobe[%0d]: cs %0d wr %0d ok %b want 1 1 1", i, cs_n, wr_n, ok);
      end
      n_checks++;
      if (bus.cpu_rdata !== m_rdata || bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0) begin
        n_fail++;
        $display("FAIL write_after[%0d]: rdata %h busy %b done %b want %h 0 0",
                 i, bus.cpu_rdata, bus.cpu_busy, bus.cpu_done, m_rdata);
      end
    end
  endtask

  // Shared body for reads: expectations come from the wait count alone.
  task automatic check_read(input string name, input logic [31:0] a, input int w,
                            input logic [31:0] d, input bit both);
    int lat, cs_n, wr_n, exp_lat; bit err, ok, exp_err;
    run_txn(1'b1, both, a, $urandom, w, d, lat, err, cs_n, wr_n, ok);
    exp_err = (w >= TIMEOUT);
    exp_lat = exp_err ? TIMEOUT + 1 : w + 2;
    m_rdata = exp_err ? ERR_DATA : d;
    n_checks++;
    if (lat != exp_lat || err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_done w=%0d: lat %0d err %b want %0d %b", name, w, lat, err, exp_lat, exp_err);
    end
    n_checks++;
    if (cs_n != exp_lat - 1 || wr_n != 0 || !ok) begin
      n_fail++;
      $display("FAIL %s_strobe w=%0d: cs %0d wr %0d ok %b want %0d 0 1", name, w, cs_n, wr_n, ok,
               exp_lat - 1);
    end
    n_checks++;
    if (bus.cpu_rdata !== m_rdata || bus.io_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rdata w=%0d: got %h cs %b want %h 0", name, w, bus.cpu_rdata, bus.io_cs,
               m_rdata);
    end
  endtask

  task automatic test_read();
    check_read("read", 32'h20, 0, 32'hCAFEBABE, 1'b0);
    check_read("read", 32'h24, 3, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 6; i++)
      check_read("read_rand", $urandom & 32'hFFFF_FFFC, $urandom_range(0, 8), $urandom,
                 1'($urandom_range(0, 1)));
  endtask

  task automatic test_timeout();
    check_read("timeout", 32'h30, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0);
    check_read("timeout", 32'h34, TIMEOUT, 32'h5555_AAAA, 1'b0);
    check_read("timeout", 32'h38, 40, 32'h7777_7777, 1'b0);
  endtask

  task automatic test_misaligned();
    int lat, cs_n, wr_n; bit err, ok, rd;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a  = (i == 0) ? 32'h13 : (($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
      rd = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_txn(rd, ~rd, a, $urandom, 0, $urandom, lat, err, cs_n, wr_n, ok);
      n_checks++;
      if (lat != 1 || err !== 1'b1 || cs_n != 0) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: lat %0d err %b cs %0d want 1 1 0", i, lat, err, cs_n);
      end
      n_checks++;
      if (bus.cpu_rdata !== m_rdata) begin
        n_fail++; $display("FAIL misaligned_rdata[%0d]: got %h want %h", i, bus.cpu_rdata, m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0, late = 0;
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h0;
    tick();
    bus.cpu_rd_req = 1'b0;
    tick();
    bus.cpu_wr_req = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h1111_2222;
    tick();
    bus.cpu_wr_req = 1'b0;
    if (bus.io_wr === 1'b1) wr_seen++;
    n_checks++;
    if (bus.io_cs !== 1'b1 || bus.io_rd !== 1'b1) begin
      n_fail++; $display("FAIL midrd_active: cs %b rd %b want 1 1", bus.io_cs, bus.io_rd);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.io_cs, bus.io_rd, bus.io_wr, bus.cpu_busy, bus.cpu_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrd_reset: cs/rd/wr/busy/done %b want 00000",
               {bus.io_cs, bus.io_rd, bus.io_wr, bus.cpu_busy, bus.cpu_done});
    end
    reset = 1'b0;
    m_rdata = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.io_wr === 1'b1) wr_seen++;
      if (bus.cpu_done === 1'b1 || bus.io_cs === 1'b1) late++;
    end
    n_checks++;
    if (wr_seen != 0 || late != 0 || bus.cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrd_after: wr %0d late %0d rdata %h want 0 0 0", wr_seen, late, bus.cpu_rdata);
    end
  endtask

  task automatic test_intr();
    int h, bad;
    bit m_pending;
    for (int r = 0; r < 3; r++) begin
      bus.io_intr = 1'b0; m_pending = 1'b0;
      tick(); tick();
      bus.io_intr = 1'b1; m_pending = 1'b1;
      tick();
      n_checks++;
      if (bus.cu_intr !== m_pending) begin
        n_fail++; $display("FAIL intr_raise[%0d]: got %b want %b", r, bus.cu_intr, m_pending);
      end
      h = $urandom_range(1, 5); bad = 0;
      for (int c = 0; c < h; c++) begin
        tick();
        if (bus.cu_intr !== 1'b1 || bus.io_intr_ack !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL intr_hold[%0d]: %0d bad cycles want 0", r, bad);
      end
      bus.cu_intr_ack = 1'b1;
      tick();
      bus.cu_intr_ack = 1'b0; m_pending = 1'b0;
      n_checks++;
      if (bus.cu_intr !== m_pending || bus.io_intr_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL intr_ack[%0d]: cu %b ack %b want 0 1", r, bus.cu_intr, bus.io_intr_ack);
      end
      bad = 0;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (bus.cu_intr !== 1'b0 || bus.io_intr_ack !== 1'b0) bad++;
      end
      bus.cu_intr_ack = 1'b1;
      tick();
      bus.cu_intr_ack = 1'b0;
      if (bus.cu_intr !== 1'b0 || bus.io_intr_ack !== 1'b0) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL intr_quiet[%0d]: %0d bad cycles want 0", r, bad);
      end
    end
    bus.io_intr = 1'b0;
    tick();
  endtask

  initial begin
    bus.cpu_rd_req = 1'b0; bus.cpu_wr_req = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_in = '0; bus.io_rdy = 1'b0;
    bus.io_intr = 1'b0; bus.cu_intr_ack = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_intr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
